ranging_scheduler: RTL
======================

# ranging_scheduler

Round-robin measurement scheduler for the shared `hc_sr04` ranging core. It time-multiplexes one core across up to four ultrasonic sensors and enforces a minimum trigger-to-trigger period so echoes from one ping settle before the next. It also aborts measurements whose echo never returns and publishes one tagged result per measurement. A per-sensor proximity alarm is derived from those results. It sits between the application logic and the `hc_sr04` core; `sel` drives the external trig/echo mux.

## Interface
- `NUM_SENS`, 4: sensors in rotation, 1..4.
- `PERIOD_CYCLES`, 720000: minimum cycles between successive `measure` pulses (60 ms at 12 MHz).
- `TIMEOUT_CYCLES`, 360000: cycles after `measure` before abort (30 ms at 12 MHz); must be < `PERIOD_CYCLES`.
- `ALARM_CM`, 20: alarm threshold in cm.

- `clk` in 1: system clock; everything is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run the rotation while high.
- `core_ready` in 1: `hc_sr04` ready (core idle).
- `core_distance_cm` in 16: `hc_sr04` distance result.
- `measure` out 1: one-cycle start pulse to the core.
- `core_abort` out 1: one-cycle pulse forcing the core back to idle.
- `sel` out 2: active sensor index for the trig/echo mux.
- `busy` out 1: high in every state except IDLE.
- `result_valid` out 1: one-cycle pulse when a result is published.
- `result_id` out 2: sensor index of the published result.
- `result_cm` out 16: distance in cm, or 16'hFFFF on timeout.
- `result_timeout` out 1: the published result is a timeout.
- `alarm` out 4: per-sensor alarm; bits at index ≥ `NUM_SENS` are tied to 0.

## Operation
- The state machine has four states: IDLE, START, BUSY, HOLDOFF.
- IDLE -> START when `enable`=1 and `core_ready`=1.
- START lasts one cycle.
  - `measure`=1 during it.
  - The period and timeout counters clear to 0.
  - The `seen_low` flag clears.
  - Next state is BUSY.
- BUSY:
  - `seen_low` sets on any cycle with `core_ready`=0.
  - Completion is the first cycle with `core_ready`=1 and `seen_low`=1. On completion, publish `result_cm`=`core_distance_cm` and `result_timeout`=0, then go to HOLDOFF.
  - Timeout is reached when the timeout counter equals `TIMEOUT_CYCLES`-1 without completion. On timeout, pulse `core_abort`, publish `result_cm`=16'hFFFF and `result_timeout`=1, then go to HOLDOFF.
  - If completion and timeout occur in the same cycle, completion wins and no abort is issued.
- HOLDOFF:
  - Wait until the period counter reaches `PERIOD_CYCLES`-1.
  - Then advance `sel` to (`sel`+1) mod `NUM_SENS`.
  - Go to START if `enable`=1 and `core_ready`=1; otherwise go to IDLE.
- `enable` falling mid-measurement does not cut the measurement short. The result is still published, HOLDOFF still runs to its end, and the machine then enters IDLE.
- `sel` changes only at HOLDOFF exit. It is stable from START through the entire measurement.
- After a return through IDLE, rotation resumes at the already-advanced `sel`.
- On a publish, `alarm[result_id]` updates to (`result_timeout`=0 and `result_cm` < `ALARM_CM`). Other alarm bits hold their values.
- Counters are saturating, sized to $clog2(`PERIOD_CYCLES`) bits, and never wrap.
- `result_id`, `result_cm` and `result_timeout` hold their values between publishes.

## Timing
- Reset values:
  - state is IDLE.
  - `sel`=0, `measure`=0, `core_abort`=0, `busy`=0.
  - `result_valid`=0, `result_id`=0, `result_cm`=0, `result_timeout`=0, `alarm`=0.
- Reset asserted mid-operation takes effect immediately and asynchronously. Release restarts from IDLE with `sel`=0.
- `measure` rises the cycle after IDLE or HOLDOFF sees its exit condition.
- `result_valid` and the result fields are registered. They appear 1 cycle after the completion or timeout detection cycle.
- `alarm` updates in the same cycle as `result_valid`.
- `core_abort` is asserted 1 cycle after the timeout detection cycle, coincident with `result_valid`.
- START-to-START spacing is exactly `PERIOD_CYCLES`+1 cycles while `enable` stays high and `core_ready` is 1 at HOLDOFF exit.

## Test plan
- **Single-sensor rotation.** `NUM_SENS`=1, `enable`=1, core model returns 100 cm after 5000 cycles. Required:
  - `measure` pulses every `PERIOD_CYCLES`+1 cycles.
  - `result_cm`=100 and `result_id`=0 on each result.
  - `alarm`=0.
- **Four-sensor round-robin.** Core returns 50, 10, 300 and 19 cm for sensors 0..3. Required:
  - `result_id` sequence 0,1,2,3,0.
  - `alarm`=4'b1010 after the first full round.
  - `sel` constant during each measurement.
- **Echo timeout.** Core holds `core_ready`=0 indefinitely for sensor 2. Required:
  - `core_abort` and `result_valid` pulse once, `TIMEOUT_CYCLES`+1 cycles after `measure`.
  - `result_cm`=16'hFFFF, `result_timeout`=1.
  - `alarm[2]` cleared.
  - Rotation continues to sensor 3.
- **Completion and timeout in the same cycle.** `core_ready` rises on exactly the timeout cycle. Required: a valid result with `result_timeout`=0 and no `core_abort` pulse.
- **Enable drop mid-measurement.** `enable` goes low in BUSY. Required:
  - The result is still published.
  - `busy` drops after HOLDOFF ends.
  - No further `measure` pulse until `enable` returns.
  - On resume, `sel` is the next sensor.
- **Reset mid-measurement.** `rst_n` asserted low in BUSY with `alarm`≠0. Required: all outputs take their reset values immediately, and the first post-release `measure` uses `sel`=0.

Source files
------------

// File: rtl/ranging_scheduler.sv
// Round-robin ping scheduler: shares one hc_sr04 ranging core across up to four sensors,
// enforces trigger spacing, aborts lost echoes and publishes tagged results with proximity alarms.
module ranging_scheduler #(
    parameter int NUM_SENS       = 4,
    parameter int PERIOD_CYCLES  = 720000,
    parameter int TIMEOUT_CYCLES = 360000,
    parameter int ALARM_CM       = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        core_ready,
    input  logic [15:0] core_distance_cm,
    output logic        measure,
    output logic        core_abort,
    output logic [1:0]  sel,
    output logic        busy,
    output logic        result_valid,
    output logic [1:0]  result_id,
    output logic [15:0] result_cm,
    output logic        result_timeout,
    output logic [3:0]  alarm
);

    localparam int              CW         = $clog2(PERIOD_CYCLES);
    localparam logic [CW-1:0]   PER_LAST   = CW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0]   TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_MAX    = {CW{1'b1}};
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [1:0]      SEL_LAST   = 2'(NUM_SENS - 1);
    localparam logic [3:0]      ALARM_MASK = 4'((1 << NUM_SENS) - 1);
    localparam logic [15:0]     ALARM_TH   = 16'(ALARM_CM);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_BUSY    = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] per_cnt_q, per_cnt_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          seen_low_q, seen_low_d;
    logic [1:0]    sel_q, sel_d;
    logic          measure_q, measure_d;
    logic          abort_q, abort_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic [1:0]    id_q, id_d;
    logic [15:0]   cm_q, cm_d;
    logic          to_q, to_d;
    logic [3:0]    alarm_q, alarm_d;

    // Next-state, counter and result computation for the scheduler FSM
    always_comb begin
        state_d    = state_q;
        per_cnt_d  = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;
        tmo_cnt_d  = (tmo_cnt_q == CNT_MAX) ? tmo_cnt_q : tmo_cnt_q + CNT_ONE;
        seen_low_d = seen_low_q;
        sel_d      = sel_q;
        measure_d  = 1'b0;
        abort_d    = 1'b0;
        valid_d    = 1'b0;
        id_d       = id_q;
        cm_d       = cm_q;
        to_d       = to_q;
        alarm_d    = alarm_q;
        case (state_q)
            S_IDLE: begin
                if (enable && core_ready) begin
                    state_d   = S_START;
                    measure_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                per_cnt_d  = '0;
                tmo_cnt_d  = '0;
                seen_low_d = 1'b0;
                state_d    = S_BUSY;
            end
            S_BUSY: begin
                if (!core_ready) begin
                    seen_low_d = 1'b1;
                end else begin
                    seen_low_d = seen_low_q;
                end
                // A genuine completion beats a simultaneous timeout, so it is tested first
                if (core_ready && seen_low_q) begin
                    state_d          = S_HOLDOFF;
                    valid_d          = 1'b1;
                    id_d             = sel_q;
                    cm_d             = core_distance_cm;
                    to_d             = 1'b0;
                    alarm_d[sel_q]   = (core_distance_cm < ALARM_TH);
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d          = S_HOLDOFF;
                    abort_d          = 1'b1;
                    valid_d          = 1'b1;
                    id_d             = sel_q;
                    cm_d             = 16'hFFFF;
                    to_d             = 1'b1;
                    alarm_d[sel_q]   = 1'b0;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_HOLDOFF: begin
                if (per_cnt_q >= PER_LAST) begin
                    sel_d = (sel_q >= SEL_LAST) ? 2'd0 : sel_q + 2'd1;
                    if (enable && core_ready) begin
                        state_d   = S_START;
                        measure_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_HOLDOFF;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        alarm_d = alarm_d & ALARM_MASK;
        busy_d  = (state_d != S_IDLE);
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            per_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            seen_low_q <= 1'b0;
            sel_q      <= 2'd0;
            measure_q  <= 1'b0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            id_q       <= 2'd0;
            cm_q       <= 16'd0;
            to_q       <= 1'b0;
            alarm_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            seen_low_q <= seen_low_d;
            sel_q      <= sel_d;
            measure_q  <= measure_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            cm_q       <= cm_d;
            to_q       <= to_d;
            alarm_q    <= alarm_d;
        end
    end

    assign measure        = measure_q;
    assign core_abort     = abort_q;
    assign sel            = sel_q;
    assign busy           = busy_q;
    assign result_valid   = valid_q;
    assign result_id      = id_q;
    assign result_cm      = cm_q;
    assign result_timeout = to_q;
    assign alarm          = alarm_q;

endmodule
